// File: rtl/vector_control_sequencer_if.sv
// Fetch/sequencer handshake and registered control-word bus
// for the vector control sequencer.
interface vector_control_sequencer_if #(
   parameter int BEAT_W = 2
);
   logic              instr_valid;
   logic              instr_ready;
   logic [4:0]        opcode;
   logic [2:0]        alu_func;
   logic              stall;
   logic              flush;
   logic              ctrl_valid;
   logic [1:0]        jmp_sel;
   logic              write_register;
   logic              mem_write;
   logic              reg_write;
   logic              vcsub;
   logic [2:0]        alu_op;
   logic [1:0]        sel_opb;
   logic              sel_rs2;
   logic [1:0]        branch_sel;
   logic [1:0]        sel_opa;
   logic              sel_write_data;
   logic              write_register_vec;
   logic [BEAT_W-1:0] vec_beat;
   logic              vec_last;
   logic              illegal;

   modport master (
      output instr_valid, opcode, alu_func, stall, flush,
      input  instr_ready, ctrl_valid, jmp_sel,
      input  write_register, mem_write, reg_write, vcsub,
      input  alu_op, sel_opb, sel_rs2, branch_sel, sel_opa,
      input  sel_write_data, write_register_vec,
      input  vec_beat, vec_last, illegal
   );

   modport slave (
      input  instr_valid, opcode, alu_func, stall, flush,
      output instr_ready, ctrl_valid, jmp_sel,
      output write_register, mem_write, reg_write, vcsub,
      output alu_op, sel_opb, sel_rs2, branch_sel, sel_opa,
      output sel_write_data, write_register_vec,
      output vec_beat, vec_last, illegal
   );
endinterface

// File: rtl/vector_control_sequencer.sv
// Registered control decoder that sequences vector ops over
// VEC_BEATS lane-group beats, with stall and flush.
module vector_control_sequencer #(
   parameter int VEC_BEATS = 4,
   parameter int BEAT_W =
      $clog2(VEC_BEATS) > 0 ? $clog2(VEC_BEATS) : 1
) (
   input logic                       clk,
   input logic                       rst,
   vector_control_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      SCALAR,
      VECTOR
   } state_t;

   localparam logic [BEAT_W-1:0] LAST_BEAT =
      BEAT_W'(VEC_BEATS - 1);
   localparam bit MULTI_BEAT = (VEC_BEATS > 1);

   state_t            state_q, state_d;
   logic [17:0]       word_q, word_d, dec_word, word_o;
   logic              ill_q, ill_d, dec_ill, dec_vec;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              vec_last, accept, ctrl_valid;

   always_comb begin
      dec_word = '0;
      dec_ill  = 1'b0;
      dec_vec  = 1'b0;
      unique case (bus.opcode)
         5'b00000: dec_word = {6'b001010, bus.alu_func,
                               9'b000000000};
         5'b01000: dec_word = 18'b001010000010000000;
         5'b01001: dec_word = 18'b001010001010000000;
         5'b00010: dec_word = 18'b001000000101000000;
         5'b00011: dec_word = 18'b001000000101000100;
         5'b00100: dec_word = 18'b000100000000001000;
         5'b00101: dec_word = 18'b000100000100001010;
         5'b10000: dec_word = 18'b010000000000000000;
         5'b00110: dec_word = 18'b100000000000000000;
         5'b10001: dec_word = 18'b000000000000000000;
         5'b01010: dec_word = 18'b000000001000010000;
         5'b01011: dec_word = 18'b000000001000100000;
         5'b11000: begin
            dec_word = {6'b000010, bus.alu_func,
                        9'b000000011};
            dec_vec  = 1'b1;
         end
         5'b11110: begin
            dec_word = 18'b000011001000000011;
            dec_vec  = 1'b1;
         end
         5'b11011: begin
            dec_word = 18'b000000000100000011;
            dec_vec  = 1'b1;
         end
         5'b11101: begin
            dec_word = 18'b000100000000001100;
            dec_vec  = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   assign ctrl_valid = (state_q != IDLE);
   assign vec_last = (state_q == SCALAR) |
                     ((state_q == VECTOR) &
                      (beat_q == LAST_BEAT));
   assign bus.instr_ready = ~rst & ~bus.stall & ~bus.flush &
                            ((state_q == IDLE) | vec_last);
   assign accept = bus.instr_valid & bus.instr_ready;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      ill_d   = ill_q;
      beat_d  = beat_q;
      if (bus.flush) begin
         state_d = IDLE;
         word_d  = '0;
         ill_d   = 1'b0;
         beat_d  = '0;
      end else if (bus.stall) begin
         state_d = state_q;
      end else if (accept) begin
         state_d = (dec_vec && MULTI_BEAT) ? VECTOR : SCALAR;
         word_d  = dec_word;
         ill_d   = dec_ill;
         beat_d  = '0;
      end else if ((state_q == VECTOR) && !vec_last) begin
         beat_d = beat_q + BEAT_W'(1);
      end else if (state_q != IDLE) begin
         state_d = IDLE;
         word_d  = '0;
         ill_d   = 1'b0;
         beat_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         ill_q   <= 1'b0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         ill_q   <= ill_d;
         beat_q  <= beat_d;
      end
   end

   // Gate again on valid so no strobe can leak from stale state.
   assign word_o = ctrl_valid ? word_q : '0;

   assign bus.ctrl_valid         = ctrl_valid;
   assign bus.jmp_sel            = word_o[17:16];
   assign bus.write_register     = word_o[15];
   assign bus.mem_write          = word_o[14];
   assign bus.reg_write          = word_o[13];
   assign bus.vcsub              = word_o[12];
   assign bus.alu_op             = word_o[11:9];
   assign bus.sel_opb            = word_o[8:7];
   assign bus.sel_rs2            = word_o[6];
   assign bus.branch_sel         = word_o[5:4];
   assign bus.sel_opa            = word_o[3:2];
   assign bus.sel_write_data     = word_o[1];
   assign bus.write_register_vec = word_o[0];
   assign bus.vec_beat           = ctrl_valid ? beat_q : '0;
   assign bus.vec_last           = ctrl_valid & vec_last;
   assign bus.illegal            = ctrl_valid & ill_q;
endmodule

// File: tb/tb_vector_control_sequencer.sv
// Directed scoreboard bench for vector_control_sequencer
// with VEC_BEATS=4.
module tb_vector_control_sequencer;
   localparam int VB = 4;
   localparam int BW = 2;

   typedef struct packed {
      logic [17:0]   word;
      logic          ill;
      logic [BW-1:0] beat;
      logic          last;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t q[$];

   vector_control_sequencer_if #(.BEAT_W(BW)) bus ();

   vector_control_sequencer #(
      .VEC_BEATS(VB),
      .BEAT_W(BW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // Reference decode: {illegal, word}
   function automatic logic [18:0] model(input logic [4:0] op,
                                         input logic [2:0] f);
      case (op)
         5'b00000: return {1'b0, 6'b001010, f, 9'b0};
         5'b01000: return {1'b0, 18'b001010000010000000};
         5'b01001: return {1'b0, 18'b001010001010000000};
         5'b00010: return {1'b0, 18'b001000000101000000};
         5'b00011: return {1'b0, 18'b001000000101000100};
         5'b00100: return {1'b0, 18'b000100000000001000};
         5'b00101: return {1'b0, 18'b000100000100001010};
         5'b10000: return {1'b0, 18'b010000000000000000};
         5'b00110: return {1'b0, 18'b100000000000000000};
         5'b10001: return {1'b0, 18'b000000000000000000};
         5'b01010: return {1'b0, 18'b000000001000010000};
         5'b01011: return {1'b0, 18'b000000001000100000};
         5'b11000: return {1'b0, 6'b000010, f, 9'b000000011};
         5'b11110: return {1'b0, 18'b000011001000000011};
         5'b11011: return {1'b0, 18'b000000000100000011};
         5'b11101: return {1'b0, 18'b000100000000001100};
         default:  return {1'b1, 18'b0};
      endcase
   endfunction

   function automatic bit is_vec(input logic [4:0] op);
      return op == 5'b11000 || op == 5'b11110 ||
             op == 5'b11011 || op == 5'b11101;
   endfunction

   function automatic bit model_ready();
      return !rst && !bus.stall && !bus.flush &&
             (q.size() == 0 || q[0].last);
   endfunction

   always @(posedge clk) begin
      if (rst || bus.flush) begin
         q.delete();
      end else begin
         logic [18:0] m;
         exp_t e;
         bit rdy;
         rdy = model_ready();
         if (q.size() != 0 && !bus.stall)
            void'(q.pop_front());
         if (bus.instr_valid && rdy) begin
            m = model(bus.opcode, bus.alu_func);
            if (is_vec(bus.opcode)) begin
               for (int b = 0; b < VB; b++) begin
                  e.word = m[17:0];
                  e.ill  = m[18];
                  e.beat = BW'(b);
                  e.last = (b == VB - 1);
                  q.push_back(e);
               end
            end else begin
               e.word = m[17:0];
               e.ill  = m[18];
               e.beat = '0;
               e.last = 1'b1;
               q.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [17:0] w;
      w = {bus.jmp_sel, bus.write_register, bus.mem_write,
           bus.reg_write, bus.vcsub, bus.alu_op, bus.sel_opb,
           bus.sel_rs2, bus.branch_sel, bus.sel_opa,
           bus.sel_write_data, bus.write_register_vec};
      chk("instr_ready", 32'(bus.instr_ready),
          32'(model_ready()));
      if (q.size() != 0) begin
         chk("ctrl_valid", 32'(bus.ctrl_valid), 32'd1);
         chk("word", 32'(w), 32'(q[0].word));
         chk("illegal", 32'(bus.illegal), 32'(q[0].ill));
         chk("vec_beat", 32'(bus.vec_beat), 32'(q[0].beat));
         chk("vec_last", 32'(bus.vec_last), 32'(q[0].last));
      end else begin
         chk("idle_valid", 32'(bus.ctrl_valid), 32'd0);
         chk("idle_word", 32'(w), 32'd0);
         chk("idle_illegal", 32'(bus.illegal), 32'd0);
         chk("idle_beat", 32'(bus.vec_beat), 32'd0);
         chk("idle_last", 32'(bus.vec_last), 32'd0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] op,
                        input logic [2:0] f);
      int n;
      n = 0;
      bus.instr_valid = 1'b1;
      bus.opcode      = op;
      bus.alu_func    = f;
      @(negedge clk);
      while (!bus.instr_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(bus.instr_ready), 32'd1);
      step(1);
      bus.instr_valid = 1'b0;
      bus.opcode      = '0;
      bus.alu_func    = '0;
   endtask

   logic [4:0] ops [12];

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.instr_valid = 1'b1;
      bus.opcode = 5'b01000;
      bus.alu_func = 3'b000;
      step(3);
      rst = 1'b0;
      bus.instr_valid = 1'b0;
      step(2);

      issue(5'b01000, 3'b000);
      step(2);

      issue(5'b00000, 3'b101);
      issue(5'b11111, 3'b111);
      step(2);

      issue(5'b11000, 3'b010);
      issue(5'b00010, 3'b000);
      step(3);

      issue(5'b11110, 3'b000);
      step(1);
      bus.stall = 1'b1;
      step(3);
      bus.stall = 1'b0;
      step(5);

      issue(5'b11101, 3'b000);
      step(2);
      bus.flush = 1'b1;
      bus.instr_valid = 1'b1;
      bus.opcode = 5'b01000;
      step(1);
      bus.flush = 1'b0;
      bus.instr_valid = 1'b0;
      step(3);

      issue(5'b11000, 3'b110);
      step(1);
      rst = 1'b1;
      bus.instr_valid = 1'b1;
      bus.opcode = 5'b00100;
      step(2);
      rst = 1'b0;
      bus.instr_valid = 1'b0;
      step(3);

      ops = '{5'b01001, 5'b00011, 5'b00100, 5'b00101,
              5'b10000, 5'b00110, 5'b10001, 5'b01010,
              5'b01011, 5'b11011, 5'b00001, 5'b11000};
      foreach (ops[i])
         issue(ops[i], 3'(i));
      step(6);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
